// File: rtl/vid_pkg.sv
// Shared constants and fetch-state encoding for the video read sequencer.
package vid_pkg;

  localparam int VID_ADDR_W     = 22;
  localparam int VID_DATA_W     = 16;
  localparam int VID_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vid_fifo.sv
// Small synchronous FIFO toward the shifter: flush, push, pop, occupancy count,
// and a registered head word that updates one edge after a pop.
module vid_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk32,
  input  logic              por,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop on an empty FIFO is a no-op here; the caller flags the underrun.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk32) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        head   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid_fetch.sv
// Video DMA read sequencer: latches the video address, issues one word read at a
// time to the arbiter, pulses vinc per completed read and buffers data for the shifter.
module vid_fetch
  import vid_pkg::*;
#(
  parameter int FIFO_DEPTH = VID_FIFO_DEPTH,
  parameter int ADDR_W     = VID_ADDR_W,
  parameter int DATA_W     = VID_DATA_W
) (
  input  logic              clk32,
  input  logic              por,
  input  logic              de,
  input  logic              vsync_start,
  input  logic [ADDR_W-1:0] vid,
  output logic              vinc,
  output logic              mreq,
  output logic [ADDR_W-2:0] maddr,
  input  logic              mack,
  input  logic [DATA_W-1:0] mdata,
  input  logic              load,
  output logic [DATA_W-1:0] sdata,
  output logic              svalid,
  output logic              underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          unused_vid_lsb;

  assign unused_vid_lsb = vid[0];

  // Frame start overrides both the returning word and any shifter pop.
  assign push   = (state == REQ) && mreq && mack && !vsync_start;
  assign pop    = load && !vsync_start;
  assign svalid = (count != '0);

  vid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk32 (clk32),
    .por   (por),
    .flush (vsync_start),
    .push  (push),
    .wdata (mdata),
    .pop   (pop),
    .head  (sdata),
    .count (count)
  );

  // GAP gives the counter one cycle to absorb vinc before the next address latch.
  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      state    <= IDLE;
      mreq     <= 1'b0;
      maddr    <= '0;
      vinc     <= 1'b0;
      underrun <= 1'b0;
    end else if (vsync_start) begin
      state    <= IDLE;
      mreq     <= 1'b0;
      vinc     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vinc <= 1'b0;
      if (load && (count == '0)) begin
        underrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (de && (count < CW'(FIFO_DEPTH))) begin
            maddr <= vid[ADDR_W-1:1];
            mreq  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (mack) begin
            mreq  <= 1'b0;
            vinc  <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          mreq  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_fetch.sv
// Directed bench for vid_fetch: bench-side arbiter and counter, scoreboard queue of
// words expected at the shifter, immediate-assertion checks at every sample point.
module tb_vid_fetch;

  logic        clk32;
  logic        por;
  logic        de;
  logic        vsync_start;
  logic [21:0] vid;
  logic        vinc;
  logic        mreq;
  logic [20:0] maddr;
  logic        mack;
  logic [15:0] mdata;
  logic        load;
  logic [15:0] sdata;
  logic        svalid;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];
  logic [15:0] exp_sdata;
  logic        exp_under;

  vid_fetch dut (
    .clk32       (clk32),
    .por         (por),
    .de          (de),
    .vsync_start (vsync_start),
    .vid         (vid),
    .vinc        (vinc),
    .mreq        (mreq),
    .maddr       (maddr),
    .mack        (mack),
    .mdata       (mdata),
    .load        (load),
    .sdata       (sdata),
    .svalid      (svalid),
    .underrun    (underrun)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete read: latch, optional ack delay (de dropped meanwhile), ack, GAP, idle.
  task automatic fetch_word(input logic [15:0] data, input int ack_delay, input bit with_load);
    de = 1'b1;
    tick();
    check_output("fetch_mreq_up", 32'(mreq), 32'd1);
    check_output("fetch_maddr", 32'(maddr), 32'(vid[21:1]));
    de = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check_output("fetch_mreq_held", 32'(mreq), 32'd1);
      check_output("fetch_no_early_vinc", 32'(vinc), 32'd0);
    end
    mack  = 1'b1;
    mdata = data;
    load  = with_load;
    tick();
    mack = 1'b0;
    load = 1'b0;
    if (with_load) begin
      if (q.size() > 0) exp_sdata = q.pop_front();
      else exp_under = 1'b1;
    end
    q.push_back(data);
    check_output("fetch_vinc", 32'(vinc), 32'd1);
    check_output("fetch_mreq_down", 32'(mreq), 32'd0);
    check_output("fetch_svalid", 32'(svalid), 32'(q.size() != 0));
    check_output("fetch_sdata", 32'(sdata), 32'(exp_sdata));
    check_output("fetch_underrun", 32'(underrun), 32'(exp_under));
    vid = vid + 22'd2;
    tick();
    check_output("gap_vinc_low", 32'(vinc), 32'd0);
    check_output("gap_mreq_low", 32'(mreq), 32'd0);
    tick();
    check_output("idle_no_new_mreq", 32'(mreq), 32'd0);
  endtask

  task automatic pop_word();
    load = 1'b1;
    tick();
    load = 1'b0;
    if (q.size() > 0) exp_sdata = q.pop_front();
    else exp_under = 1'b1;
    check_output("pop_sdata", 32'(sdata), 32'(exp_sdata));
    check_output("pop_svalid", 32'(svalid), 32'(q.size() != 0));
    check_output("pop_underrun", 32'(underrun), 32'(exp_under));
  endtask

  initial begin
    por         = 1'b1;
    de          = 1'b0;
    vsync_start = 1'b0;
    vid         = '0;
    mack        = 1'b0;
    mdata       = '0;
    load        = 1'b0;
    exp_sdata   = '0;
    exp_under   = 1'b0;

    // Reset values, then a reset pulse in the middle of a read.
    tick();
    check_output("rst_mreq", 32'(mreq), 32'd0);
    check_output("rst_maddr", 32'(maddr), 32'd0);
    check_output("rst_svalid", 32'(svalid), 32'd0);
    por = 1'b0;
    de  = 1'b1;
    vid = 22'h000100;
    tick();
    check_output("pre_rst_mreq", 32'(mreq), 32'd1);
    check_output("pre_rst_maddr", 32'(maddr), 32'h80);
    de  = 1'b0;
    por = 1'b1;
    #1;
    check_output("async_rst_mreq", 32'(mreq), 32'd0);
    check_output("async_rst_maddr", 32'(maddr), 32'd0);
    check_output("async_rst_vinc", 32'(vinc), 32'd0);
    check_output("async_rst_sdata", 32'(sdata), 32'd0);
    check_output("async_rst_underrun", 32'(underrun), 32'd0);
    #1;
    por   = 1'b0;
    mack  = 1'b1;
    mdata = 16'hDEAD;
    tick();
    mack = 1'b0;
    check_output("late_mack_svalid", 32'(svalid), 32'd0);
    check_output("late_mack_vinc", 32'(vinc), 32'd0);
    tick();
    check_output("late_mack_svalid2", 32'(svalid), 32'd0);

    // Continuous fill: four back-to-back reads, then requests stop at full.
    $display("[TB] fill from 0x03F000");
    de  = 1'b1;
    vid = 22'h03F000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("fill_mreq", 32'(mreq), 32'd1);
      check_output("fill_maddr", 32'(maddr), 32'h01F800 + 32'(i));
      mack  = 1'b1;
      mdata = 16'hA000 + 16'(i);
      q.push_back(mdata);
      tick();
      mack = 1'b0;
      check_output("fill_vinc", 32'(vinc), 32'd1);
      check_output("fill_mreq_down", 32'(mreq), 32'd0);
      vid = vid + 22'd2;
      tick();
      check_output("fill_vinc_once", 32'(vinc), 32'd0);
    end
    tick();
    check_output("full_no_mreq", 32'(mreq), 32'd0);
    tick();
    check_output("full_no_mreq2", 32'(mreq), 32'd0);
    check_output("full_svalid", 32'(svalid), 32'd1);
    de = 1'b0;
    for (int i = 0; i < 4; i++) pop_word();

    // Two words out in order with one-cycle latency.
    $display("[TB] ordered pop");
    fetch_word(16'h1111, 0, 1'b0);
    fetch_word(16'h2222, 0, 1'b0);
    pop_word();
    pop_word();

    // Underrun is sticky through a refill and cleared by frame start.
    $display("[TB] underrun");
    pop_word();
    fetch_word(16'h3333, 1, 1'b0);
    check_output("underrun_sticky", 32'(underrun), 32'd1);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    q.delete();
    exp_under = 1'b0;
    check_output("vsync_underrun_clr", 32'(underrun), 32'd0);
    check_output("vsync_flush", 32'(svalid), 32'd0);
    check_output("vsync_sdata_hold", 32'(sdata), 32'(exp_sdata));

    // Push and pop together, then empty push with load (no bypass).
    $display("[TB] simultaneous push/pop");
    fetch_word(16'h4444, 0, 1'b0);
    fetch_word(16'h5555, 0, 1'b1);
    pop_word();
    fetch_word(16'h6666, 0, 1'b1);

    // Frame start racing an ack and a load.
    $display("[TB] vsync vs mack");
    de = 1'b1;
    tick();
    check_output("race_mreq", 32'(mreq), 32'd1);
    de          = 1'b0;
    vsync_start = 1'b1;
    mack        = 1'b1;
    mdata       = 16'hBEEF;
    load        = 1'b1;
    tick();
    vsync_start = 1'b0;
    mack        = 1'b0;
    load        = 1'b0;
    q.delete();
    exp_under = 1'b0;
    check_output("race_vinc", 32'(vinc), 32'd0);
    check_output("race_mreq_down", 32'(mreq), 32'd0);
    check_output("race_svalid", 32'(svalid), 32'd0);
    check_output("race_underrun", 32'(underrun), 32'd0);
    check_output("race_sdata", 32'(sdata), 32'(exp_sdata));
    tick();
    check_output("race_vinc_after", 32'(vinc), 32'd0);
    check_output("race_mreq_after", 32'(mreq), 32'd0);

    // de falls during REQ; a slow ack still completes the read.
    $display("[TB] slow ack after de drop");
    fetch_word(16'h7777, 5, 1'b0);
    pop_word();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
